// File: rtl/timer_array_pkg.sv
// Shared definitions for the timer array: register offsets, CTRL bit
// positions and the per-channel FSM state encoding.
package timer_array_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE    = 1;
  localparam int CTRL_IM      = 2;
  localparam int CTRL_PSC_LSB = 8;
  localparam int CTRL_PSC_MSB = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2
  } ch_state_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: control/preset registers, down-counter, pending flag.
// Optional prescaler enabled by TIMER_ARRAY_PRESCALE_EN.
//
// state    | meaning
// ST_IDLE  | counter held, waiting for EN to be written 1
// ST_LOAD  | counter loaded from PRESET this cycle
// ST_COUNT | counter decrements on each tick, terminal at zero
module timer_channel
  import timer_array_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_we,
  input  logic             preset_we,
  input  logic             status_we,
  input  logic [31:0]      wdata,
  output logic [31:0]      ctrl,
  output logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] count,
  output logic             pending
);

  ch_state_t        state, state_d;
  logic             en, mode, im;
  logic             tick;
  logic             do_load, do_dec, do_term;
  logic             wr_en, wr_dis;
  logic             unused_wdata;

  assign wr_en        = ctrl_we &  wdata[CTRL_EN];
  assign wr_dis       = ctrl_we & ~wdata[CTRL_EN];
  assign unused_wdata = ^wdata;

`ifdef TIMER_ARRAY_PRESCALE_EN
  logic [7:0] psc, psc_cnt;

  assign tick = (psc_cnt == psc);
  assign ctrl = {16'b0, psc, 5'b0, im, mode, en};

  // prescale counter restarts at every load so each period is exact
  always_ff @(posedge clk) begin
    if (rst)
      psc_cnt <= '0;
    else if (state == ST_LOAD)
      psc_cnt <= '0;
    else if (state == ST_COUNT && !wr_dis)
      psc_cnt <= tick ? 8'd0 : psc_cnt + 8'd1;
  end
`else
  assign tick = 1'b1;
  assign ctrl = {29'b0, im, mode, en};
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // next state and datapath strobes; disabling freezes everything at once
  always_comb begin
    state_d = state;
    do_load = 1'b0;
    do_dec  = 1'b0;
    do_term = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (wr_dis) begin
          state_d = ST_IDLE;
        end else begin
          do_load = 1'b1;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (wr_dis) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (count == '0) begin
            do_term = 1'b1;
            state_d = mode ? ST_LOAD : ST_IDLE;
          end else begin
            do_dec = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // registers, counter and pending flag; terminal count beats W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b0;
      mode    <= 1'b0;
      im      <= 1'b0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
`ifdef TIMER_ARRAY_PRESCALE_EN
      psc     <= '0;
`endif
    end else begin
      if (ctrl_we) begin
        en   <= wdata[CTRL_EN];
        mode <= wdata[CTRL_MODE];
        im   <= wdata[CTRL_IM];
`ifdef TIMER_ARRAY_PRESCALE_EN
        psc  <= wdata[CTRL_PSC_MSB:CTRL_PSC_LSB];
`endif
      end else if (do_term && !mode) begin
        en <= 1'b0;
      end

      if (preset_we) preset <= wdata[WIDTH-1:0];

      if (do_load)     count <= preset;
      else if (do_dec) count <= count - 1'b1;

      if (do_term)                       pending <= 1'b1;
      else if (status_we && wdata[0])    pending <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_array.sv
// Array of N_CH independent down-counting timers behind a small register
// file. Top level does address decode, read mux and interrupt reduction.
// Optional per-channel prescaler: define TIMER_ARRAY_PRESCALE_EN.
module timer_array
  import timer_array_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(N_CH) + 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [N_CH-1:0] irq,
  output logic            irq_any
);

  localparam int CW = (AW > 2) ? AW - 2 : 1;

  logic [CW-1:0]    ch_idx;
  logic [1:0]       reg_sel;
  logic             in_range;
  logic [31:0]      ctrl_r   [N_CH];
  logic [WIDTH-1:0] preset_r [N_CH];
  logic [WIDTH-1:0] count_r  [N_CH];
  logic [N_CH-1:0]  pend;

  if (AW > 2) begin : g_idx
    assign ch_idx = addr[AW-1:2];
  end else begin : g_idx_single
    assign ch_idx = '0;
  end

  assign reg_sel  = addr[1:0];
  assign in_range = (32'(ch_idx) < N_CH);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [CW-1:0] IDX = CW'(i);
    logic sel;

    assign sel = we && in_range && (ch_idx == IDX);

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .ctrl_we   (sel && reg_sel == REG_CTRL),
      .preset_we (sel && reg_sel == REG_PRESET),
      .status_we (sel && reg_sel == REG_STATUS),
      .wdata     (wdata),
      .ctrl      (ctrl_r[i]),
      .preset    (preset_r[i]),
      .count     (count_r[i]),
      .pending   (pend[i])
    );

    assign irq[i] = pend[i] & ctrl_r[i][CTRL_IM];
  end

  assign irq_any = |irq;

  // read mux; unmapped channels read as zero
  always_comb begin
    rdata = '0;
    if (in_range) begin
      case (reg_sel)
        REG_CTRL:   rdata = ctrl_r[ch_idx];
        REG_PRESET: rdata = 32'(preset_r[ch_idx]);
        REG_COUNT:  rdata = 32'(count_r[ch_idx]);
        default:    rdata = {31'b0, pend[ch_idx]};
      endcase
    end
  end

endmodule

// File: tb/tb_timer_array.sv
// Directed self-checking bench for timer_array (N_CH=3 so channel 3 is
// unmapped, WIDTH=16 to exercise PRESET zero-extension).
module tb_timer_array;

  localparam int N_CH  = 3;
  localparam int WIDTH = 16;
  localparam int AW    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   addr;
  logic            we;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [N_CH-1:0] irq;
  logic            irq_any;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  timer_array #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq),
    .irq_any (irq_any)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    ticks(2);
    rst = 1'b0;
    tick();

    check_reg("rst_ctrl0", 4'd0, 32'h0);
    check_reg("rst_preset0", 4'd1, 32'h0);
    check_reg("rst_count0", 4'd2, 32'h0);
    check_reg("rst_status0", 4'd3, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_irq_any", 32'(irq_any), 32'h0);

    // ch0 one-shot, PRESET=5: irq at edge 7
    wr(4'd1, 32'd5);
    wr(4'd0, 32'h5);
    ticks(6);
    check("oneshot_irq_e6", 32'(irq[0]), 32'h0);
    tick();
    check("oneshot_irq_e7", 32'(irq[0]), 32'h1);
    check("oneshot_irq_any", 32'(irq_any), 32'h1);
    check_reg("oneshot_ctrl", 4'd0, 32'h4);
    check_reg("oneshot_count", 4'd2, 32'h0);
    wr(4'd3, 32'h1);
    check("w1c_irq0", 32'(irq[0]), 32'h0);

    // ch1 auto-reload, PRESET=3: period 5, W1C gap of 4 cycles
    wr(4'd5, 32'd3);
    wr(4'd4, 32'h7);
    ticks(4);
    check("reload_irq_e4", 32'(irq[1]), 32'h0);
    tick();
    check("reload_irq_e5", 32'(irq[1]), 32'h1);
    wr(4'd7, 32'h1);
    check("reload_w1c_e6", 32'(irq[1]), 32'h0);
    ticks(3);
    check("reload_w1c_e9", 32'(irq[1]), 32'h0);
    tick();
    check("reload_irq_e10", 32'(irq[1]), 32'h1);
    wr(4'd4, 32'h0);
    wr(4'd7, 32'h1);
    check("reload_off_irq", 32'(irq), 32'h0);

    // ch0 disabled at COUNT=10: frozen, no irq
    wr(4'd1, 32'd20);
    wr(4'd0, 32'h5);
    ticks(11);
    check_reg("freeze_count_before", 4'd2, 32'd10);
    wr(4'd0, 32'h0);
    ticks(20);
    check_reg("freeze_count_after", 4'd2, 32'd10);
    check_reg("freeze_status", 4'd3, 32'h0);
    check("freeze_irq", 32'(irq), 32'h0);

    // W1C in the terminal-count cycle: pending wins
    wr(4'd1, 32'd2);
    wr(4'd0, 32'h5);
    ticks(3);
    wr(4'd3, 32'h1);
    check_reg("tc_w1c_status", 4'd3, 32'h1);
    check("tc_w1c_irq", 32'(irq[0]), 32'h1);
    wr(4'd3, 32'h1);
    check_reg("tc_w1c_clear", 4'd3, 32'h0);

    // ch2 PRESET=0 auto-reload, IM off: pending every 2 cycles, no irq
    wr(4'd9, 32'd0);
    wr(4'd8, 32'h3);
    tick();
    check_reg("p0_status_e1", 4'd11, 32'h0);
    tick();
    check_reg("p0_status_e2", 4'd11, 32'h1);
    check("p0_irq_masked", 32'(irq), 32'h0);
    wr(4'd11, 32'h1);
    check_reg("p0_status_e3", 4'd11, 32'h0);
    tick();
    check_reg("p0_status_e4", 4'd11, 32'h1);
    wr(4'd8, 32'h0);
    wr(4'd11, 32'h1);

    // PRESET rewritten while counting: count unaffected, used on next load
    wr(4'd5, 32'd10);
    wr(4'd4, 32'h5);
    tick();
    wr(4'd5, 32'd3);
    check_reg("preset_wr_count", 4'd6, 32'd9);
    ticks(9);
    check("preset_wr_irq_e11", 32'(irq[1]), 32'h0);
    tick();
    check("preset_wr_irq_e12", 32'(irq[1]), 32'h1);
    wr(4'd7, 32'h1);
    wr(4'd4, 32'h5);
    tick();
    check_reg("preset_wr_reload", 4'd6, 32'd3);
    wr(4'd4, 32'h0);

    // unmapped channel 3
    wr(4'd12, 32'h5);
    check_reg("oor_ctrl", 4'd12, 32'h0);
    check_reg("oor_preset", 4'd13, 32'h0);
    check("oor_irq", 32'(irq), 32'h0);

    // PRESET zero-extension and CTRL upper bits
    wr(4'd1, 32'hFFFF_FFFF);
    check_reg("preset_zext", 4'd1, 32'h0000_FFFF);
    wr(4'd0, 32'h0000_0306);
`ifdef TIMER_ARRAY_PRESCALE_EN
    check_reg("ctrl_psc", 4'd0, 32'h0000_0306);
`else
    check_reg("ctrl_psc", 4'd0, 32'h0000_0006);
`endif
    wr(4'd0, 32'h0);

    // reset mid-count with a concurrent PRESET write
    wr(4'd5, 32'd3);
    wr(4'd1, 32'd100);
    wr(4'd0, 32'h5);
    ticks(5);
    check_reg("pre_rst_count", 4'd2, 32'd96);
    rst   = 1'b1;
    addr  = 4'd1;
    wdata = 32'h55;
    we    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    we  = 1'b0;
    check_reg("rst2_ctrl0", 4'd0, 32'h0);
    check_reg("rst2_preset0", 4'd1, 32'h0);
    check_reg("rst2_count0", 4'd2, 32'h0);
    check_reg("rst2_status0", 4'd3, 32'h0);
    check_reg("rst2_preset1", 4'd5, 32'h0);
    check("rst2_irq_any", 32'(irq_any), 32'h0);
    tick();
    check_reg("rst2_count0_hold", 4'd2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
